mdu_sched: RTL

Multi-cycle multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It accepts one MDU operation per issue, computes the result at issue, and holds it in a pending register for the fixed architectural latency before committing it to HI/LO. It drives the busy/stall signal the hazard unit uses and suppresses issue when the E-stage instruction is flushed by an exception or interrupt (`req`).

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_sched.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the E-stage multiply/divide sequencer.
// The CU decode produces the same 4-bit op codes, so keep them in step.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W        = 4;

    function automatic logic is_md(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sched.sv
// Multiply/divide sequencer: computes the result at issue, holds it in a
// pending register for the architectural latency, then commits to HI/LO.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    mdu_state_e state;
    logic       start;

    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        div_zero, div_ovf;

    assign state = (cnt_q == '0) ? ST_IDLE : ST_RUN;
    assign start = (state == ST_IDLE) && !req && is_md(op);

    assign prod_s   = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u   = {32'b0, rs} * {32'b0, rt};
    assign div_zero = (rt == 32'h0);
    assign div_ovf  = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    // Guards keep the divide operators away from zero and the one signed
    // overflow pair, where the architected result is fixed.
    always_comb begin
        quo_s = 32'h0;
        rem_s = 32'h0;
        quo_u = 32'h0;
        rem_u = 32'h0;
        if (div_ovf) begin
            quo_s = 32'h8000_0000;
        end else if (!div_zero) begin
            quo_s = $signed(rs) / $signed(rt);
            rem_s = $signed(rs) % $signed(rt);
        end
        if (!div_zero) begin
            quo_u = rs / rt;
            rem_u = rs % rt;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state)
            ST_IDLE: begin
                if (!req) begin
                    case (op)
                        MDU_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d = CNT_W'(MULT_LAT);
                        end
                        MDU_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d = CNT_W'(MULT_LAT);
                        end
                        // HI/LO cannot change while running, so a divide by
                        // zero simply pends the current values.
                        MDU_DIV: begin
                            pend_hi_d = div_zero ? hi_q : rem_s;
                            pend_lo_d = div_zero ? lo_q : quo_s;
                            cnt_d     = CNT_W'(DIV_LAT);
                        end
                        MDU_DIVU: begin
                            pend_hi_d = div_zero ? hi_q : rem_u;
                            pend_lo_d = div_zero ? lo_q : quo_u;
                            cnt_d     = CNT_W'(DIV_LAT);
                        end
                        MDU_MTHI: hi_d = rs;
                        MDU_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= 32'h0;
            lo_q      <= 32'h0;
            pend_hi_q <= 32'h0;
            pend_lo_q <= 32'h0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy  = (state == ST_RUN);
    assign stall = busy | start;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        rdata = 32'h0;
        if (op == MDU_MFHI) rdata = hi_q;
        else if (op == MDU_MFLO) rdata = lo_q;
    end

endmodule
